// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the multi-precision adder: word width, FSM states and
// the word-index width helper.
package wide_add_sequencer_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-word build still needs a 1-bit index register.
  function automatic int idxWidth(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/wide_add_sequencer_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with group generate/propagate
// chained between groups; exposes whole-word propagate/generate as gp/gg.
module CLA_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        gp,
  output logic        gg
);

  logic [31:0] p;
  logic [31:0] g;
  logic [32:0] c;
  logic [7:0]  grpP;
  logic [7:0]  grpG;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    grpP = '0;
    grpG = '0;
    gg   = 1'b0;
    c[0] = cin;
    for (int k = 0; k < 8; k++) begin
      grpP[k] = &p[4*k +: 4];
      grpG[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
              | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = grpG[k] | (grpP[k] & c[4*k]);
    end
    // Fold group terms LSB-first so gg is the generate of the whole word.
    for (int k = 0; k < 8; k++) begin
      gg = grpG[k] | (grpP[k] & gg);
    end
    sum  = p ^ c[31:0];
    cout = c[32];
    gp   = &grpP;
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision adder front end: accepts a W-bit operand pair, feeds one 32-bit
// CLA a word per cycle (LSW first, carry chained) and returns sum, carry and overflow.
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter  int NWORDS = 2,
  localparam int W      = WORD_W * NWORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf
);

  localparam int IDX_W = idxWidth(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_t              stateQ;
  logic [W-1:0]        aShQ, bShQ, aShD, bShD;
  logic [W-1:0]        resultQ, resultD;
  logic                carryQ;
  logic [IDX_W-1:0]    idxQ;
  logic                signAQ, signBQ;
  logic [WORD_W-1:0]   claSum;
  logic                claCout;
  logic                unusedClaGp, unusedClaGg;

  CLA_32bit uCla (
    .a    (aShQ[WORD_W-1:0]),
    .b    (bShQ[WORD_W-1:0]),
    .cin  (carryQ),
    .sum  (claSum),
    .cout (claCout),
    .gp   (unusedClaGp),
    .gg   (unusedClaGg)
  );

  assign aShD = aShQ >> WORD_W;
  assign bShD = bShQ >> WORD_W;

  // Each new word enters at the top so the LSW ends up at bit 0 after NWORDS cycles.
  generate
    if (NWORDS == 1) begin : gSingle
      assign resultD = claSum;
    end else begin : gMulti
      assign resultD = {claSum, resultQ[W-1:WORD_W]};
    end
  endgenerate

  assign out_sum = resultQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ    <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      resultQ   <= '0;
      aShQ      <= '0;
      bShQ      <= '0;
      carryQ    <= 1'b0;
      idxQ      <= '0;
      signAQ    <= 1'b0;
      signBQ    <= 1'b0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (in_valid) begin
            aShQ     <= in_a;
            bShQ     <= in_b;
            carryQ   <= in_cin;
            idxQ     <= '0;
            signAQ   <= in_a[W-1];
            signBQ   <= in_b[W-1];
            in_ready <= 1'b0;
            stateQ   <= RUN;
          end
        end
        RUN: begin
          resultQ <= resultD;
          carryQ  <= claCout;
          aShQ    <= aShD;
          bShQ    <= bShD;
          idxQ    <= idxQ + 1'b1;
          if (idxQ == LAST_IDX) begin
            out_cout  <= claCout;
            out_ovf   <= (signAQ == signBQ) && (claSum[WORD_W-1] != signAQ);
            out_valid <= 1'b1;
            stateQ    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            stateQ    <= IDLE;
          end
        end
        default: begin
          stateQ    <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer at NWORDS=2, 1 and 4: drivers queue the
// expected result per op, per-instance monitors pop and compare when out_valid shows.
module tb_wide_add_sequencer;

  typedef struct packed {
    logic [127:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         inValid  [3];
  logic         inReady  [3];
  logic [127:0] inA      [3];
  logic [127:0] inB      [3];
  logic         inCin    [3];
  logic         outValid [3];
  logic         outReady [3];
  logic [127:0] outSum   [3];
  logic         outCout  [3];
  logic         outOvf   [3];

  logic [63:0]  sum0;
  logic [31:0]  sum1;
  logic [127:0] sum2;

  exp_t expQ [3][$];
  int   accQ [3][$];
  int   cycle = 0;
  int   nChecks = 0;
  int   nFails = 0;
  int   opsSeen = 0;
  int   opsOk = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  wide_add_sequencer #(.NWORDS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_a(inA[0][63:0]), .in_b(inB[0][63:0]), .in_cin(inCin[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_sum(sum0),
    .out_cout(outCout[0]), .out_ovf(outOvf[0])
  );

  wide_add_sequencer #(.NWORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_a(inA[1][31:0]), .in_b(inB[1][31:0]), .in_cin(inCin[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_sum(sum1),
    .out_cout(outCout[1]), .out_ovf(outOvf[1])
  );

  wide_add_sequencer #(.NWORDS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .in_a(inA[2]), .in_b(inB[2]), .in_cin(inCin[2]),
    .out_valid(outValid[2]), .out_ready(outReady[2]), .out_sum(sum2),
    .out_cout(outCout[2]), .out_ovf(outOvf[2])
  );

  assign outSum[0] = {64'b0, sum0};
  assign outSum[1] = {96'b0, sum1};
  assign outSum[2] = sum2;

  function automatic int nwOf(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  // Reference model: full-width add of the masked operands plus carry-in.
  function automatic exp_t model(input int w, input logic [127:0] a, input logic [127:0] b,
                                 input logic cin);
    logic [128:0] full;
    logic [127:0] m;
    exp_t         e;
    m      = (w == 128) ? {128{1'b1}} : ((128'(1) << w) - 128'(1));
    full   = {1'b0, a & m} + {1'b0, b & m} + 129'(cin);
    e.sum  = full[127:0] & m;
    e.cout = full[w];
    e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic failNow(input string name);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s: timed out", name);
  endtask

  // One monitor per instance; values are sampled on the falling edge.
  for (genvar gd = 0; gd < 3; gd++) begin : gMon
    exp_t cur;
    bit   haveCur = 1'b0;
    always @(negedge clk) begin
      if (rst) begin
        haveCur = 1'b0;
      end else begin
        if (inValid[gd] && inReady[gd]) accQ[gd].push_back(cycle + 1);
        if (outValid[gd]) begin
          checkOutput($sformatf("inReadyLowInDone[%0d]", gd), 128'(inReady[gd]), 128'(0));
          if (!haveCur) begin
            if (expQ[gd].size() == 0 || accQ[gd].size() == 0) begin
              nChecks++;
              nFails++;
              $display("[TB] FAIL unexpectedResult[%0d]: got sum %h, expected no result", gd, outSum[gd]);
            end else begin
              cur = expQ[gd].pop_front();
              opsSeen++;
              if (outSum[gd] === cur.sum && outCout[gd] === cur.cout && outOvf[gd] === cur.ovf)
                opsOk++;
              checkOutput($sformatf("sum[%0d]", gd), outSum[gd], cur.sum);
              checkOutput($sformatf("cout[%0d]", gd), 128'(outCout[gd]), 128'(cur.cout));
              checkOutput($sformatf("ovf[%0d]", gd), 128'(outOvf[gd]), 128'(cur.ovf));
              checkOutput($sformatf("latency[%0d]", gd), 128'(cycle - accQ[gd].pop_front()),
                          128'(nwOf(gd)));
            end
            haveCur = 1'b1;
          end else begin
            checkOutput($sformatf("heldSum[%0d]", gd), outSum[gd], cur.sum);
            checkOutput($sformatf("heldCout[%0d]", gd), 128'(outCout[gd]), 128'(cur.cout));
            checkOutput($sformatf("heldOvf[%0d]", gd), 128'(outOvf[gd]), 128'(cur.ovf));
          end
          if (outReady[gd]) haveCur = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input int d, input logic [127:0] a, input logic [127:0] b,
                               input logic cin, input exp_t e);
    bit accepted;
    accepted = 1'b0;
    expQ[d].push_back(e);
    inA[d]     = a;
    inB[d]     = b;
    inCin[d]   = cin;
    inValid[d] = 1'b1;
    for (int t = 0; t < 200 && !accepted; t++) begin
      if (inReady[d]) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    inValid[d] = 1'b0;
    if (!accepted) failNow($sformatf("accept[%0d]", d));
  endtask

  task automatic waitIdle(input int d);
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 500 && !idle; t++) begin
      @(posedge clk);
      #1;
      idle = (expQ[d].size() == 0) && !outValid[d];
    end
    if (!idle) failNow($sformatf("drain[%0d]", d));
  endtask

  function automatic exp_t mk(input logic [127:0] s, input logic c, input logic o);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = o;
    return e;
  endfunction

  task automatic randomOps(input int d, input int n);
    logic [127:0] a, b;
    logic         cin;
    for (int i = 0; i < n; i++) begin
      a   = {$urandom, $urandom, $urandom, $urandom};
      b   = {$urandom, $urandom, $urandom, $urandom};
      cin = 1'($urandom_range(0, 1));
      if (i % 10 == 0) a = {128{1'b1}};
      applyStimulus(d, a, b, cin, model(32 * nwOf(d), a, b, cin));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      inValid[d]  = 1'b0;
      inA[d]      = '0;
      inB[d]      = '0;
      inCin[d]    = 1'b0;
      outReady[d] = 1'b1;
    end
    #1 rst = 1'b1;
    #2;
    for (int d = 0; d < 3; d++) begin
      checkOutput("resetInReady", 128'(inReady[d]), 128'(1));
      checkOutput("resetOutValid", 128'(outValid[d]), 128'(0));
      checkOutput("resetSum", outSum[d], 128'(0));
      checkOutput("resetCout", 128'(outCout[d]), 128'(0));
      checkOutput("resetOvf", 128'(outOvf[d]), 128'(0));
    end
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] directed vectors, NWORDS=2");
    applyStimulus(0, 128'h0000_0000_FFFF_FFFF, 128'h1, 1'b0, mk(128'h0000_0001_0000_0000, 1'b0, 1'b0));
    waitIdle(0);
    applyStimulus(0, 128'hFFFF_FFFF_FFFF_FFFF, 128'h0, 1'b1, mk(128'h0, 1'b1, 1'b0));
    waitIdle(0);
    applyStimulus(0, 128'h7FFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, mk(128'h8000_0000_0000_0000, 1'b0, 1'b1));
    waitIdle(0);

    $display("[TB] backpressure with a pending new op");
    outReady[0] = 1'b0;
    applyStimulus(0, 128'h0123_4567_89AB_CDEF, 128'h1111_1111_1111_1111, 1'b0,
                  mk(128'h1234_5678_9ABC_DF00, 1'b0, 1'b0));
    fork
      applyStimulus(0, 128'h8000_0000_0000_0000, 128'h8000_0000_0000_0000, 1'b1,
                    mk(128'h1, 1'b1, 1'b1));
      begin
        repeat (7) @(posedge clk);
        #1 outReady[0] = 1'b1;
      end
    join
    waitIdle(0);

    $display("[TB] reset one cycle after accept");
    applyStimulus(0, 128'hDEAD_BEEF_0000_0001, 128'h1, 1'b0, mk(128'hDEAD_BEEF_0000_0002, 1'b0, 1'b0));
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midResetInReady", 128'(inReady[0]), 128'(1));
    checkOutput("midResetOutValid", 128'(outValid[0]), 128'(0));
    checkOutput("midResetSum", outSum[0], 128'(0));
    checkOutput("midResetCout", 128'(outCout[0]), 128'(0));
    checkOutput("midResetOvf", 128'(outOvf[0]), 128'(0));
    expQ[0].delete();
    accQ[0].delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("noPartialResult", 128'(outValid[0]), 128'(0));
    applyStimulus(0, 128'h0000_0001_0000_0002, 128'h0000_0003_0000_0004, 1'b1,
                  mk(128'h0000_0004_0000_0007, 1'b0, 1'b0));
    waitIdle(0);

    $display("[TB] directed vectors, NWORDS=1 and NWORDS=4");
    applyStimulus(1, 128'hFFFF_FFFF, 128'h1, 1'b0, mk(128'h0, 1'b1, 1'b0));
    waitIdle(1);
    applyStimulus(2, {128{1'b1}}, 128'h0, 1'b1, mk(128'h0, 1'b1, 1'b0));
    waitIdle(2);
    applyStimulus(2, 128'h7FFF_FFFF_0000_0000_0000_0000_0000_0000, 128'h0000_0001_0000_0000_0000_0000_0000_0000,
                  1'b0, mk(128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1));
    waitIdle(2);

    $display("[TB] random ops, NWORDS=1 and NWORDS=4");
    fork
      randomOps(1, 100);
      randomOps(2, 100);
    join
    waitIdle(1);
    waitIdle(2);

    $display("[TB] results matching the model: %0d of %0d", opsOk, opsSeen);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
